// File: rtl/wb_commit_stage_pkg.sv
// Shared defaults and helpers for the multi-lane commit stage.
// Lane layout is {gr_we, dest, result, pc}, msb to lsb.
package wb_commit_stage_pkg;

    localparam int WS_LANES  = 2;
    localparam int WS_DEPTH  = 4;
    localparam int WS_DATA_W = 32;
    localparam int WS_PC_W   = 32;
    localparam int WS_REG_AW = 5;

    function automatic int unsigned popcnt(input logic [31:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(m[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/wb_commit_buf.sv
// In-order commit buffer: multi-write at tail, single pop at head,
// entries exposed rotated so index 0 is always the oldest.
module wb_commit_buf
    import wb_commit_stage_pkg::*;
#(
    parameter  int LANES  = WS_LANES,
    parameter  int DEPTH  = WS_DEPTH,
    parameter  int ENT_W  = 70,
    parameter  int VIEW_W = 38,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [LANES-1:0]        wr_mask,
    input  logic [LANES*ENT_W-1:0]  wr_data,
    output logic [CNT_W-1:0]        count,
    output logic [ENT_W-1:0]        head_ent,
    output logic [DEPTH-1:0]        ent_valid,
    output logic [DEPTH*VIEW_W-1:0] ent_view
);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] wr_cnt;
    logic             rd_en;
    logic [ENT_W-1:0] ent;

    assign rd_en  = (count != '0);
    assign wr_cnt = wr_en ? CNT_W'(popcnt(32'(wr_mask))) : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(rd_en);
            tail  <= tail + PTR_W'(wr_cnt);
            count <= count + wr_cnt - CNT_W'(rd_en);
        end
    end

    // Payload needs no reset: validity is carried by count alone.
    always_ff @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            if (wr_en && wr_mask[j]) begin
                mem[tail + PTR_W'(j)] <= wr_data[j*ENT_W +: ENT_W];
            end
        end
    end

    assign head_ent = mem[head];

    always_comb begin
        ent_valid = '0;
        ent_view  = '0;
        ent       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent          = mem[head + PTR_W'(i)];
            ent_valid[i] = CNT_W'(i) < count;
            ent_view[i*VIEW_W +: VIEW_W] = ent[ENT_W-1 -: VIEW_W];
        end
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback: buffers MEM results, retires one per cycle
// in order, and publishes pending results to decode by age.
module wb_commit_stage
    import wb_commit_stage_pkg::*;
#(
    parameter  int LANES  = WS_LANES,
    parameter  int DEPTH  = WS_DEPTH,
    parameter  int DATA_W = WS_DATA_W,
    parameter  int PC_W   = WS_PC_W,
    parameter  int REG_AW = WS_REG_AW,
    localparam int LANE_W = 1 + REG_AW + DATA_W + PC_W,
    localparam int RF_W   = 1 + REG_AW + DATA_W
) (
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    ws_allowin,
    input  logic [LANES-1:0]        ms_to_ws_valid,
    input  logic [LANES*LANE_W-1:0] ms_to_ws_bus,
    output logic [RF_W-1:0]         ws_to_rf_bus,
    output logic                    ws_to_ds_valid,
    output logic [DEPTH-1:0]        ws_fwd_valid,
    output logic [DEPTH*REG_AW-1:0] ws_fwd_dest,
    output logic [DEPTH*DATA_W-1:0] ws_fwd_data,
    output logic [PC_W-1:0]         debug_wb_pc,
    output logic [3:0]              debug_wb_rf_we,
    output logic [REG_AW-1:0]       debug_wb_rf_wnum,
    output logic [DATA_W-1:0]       debug_wb_rf_wdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]        count;
    logic [LANE_W-1:0]       head_ent;
    logic [DEPTH-1:0]        ent_valid;
    logic [DEPTH*RF_W-1:0]   ent_view;
    logic [LANES-1:0]        enq_mask;
    logic                    run;
    logic                    enq;
    logic                    head_vld;
    logic                    head_we;
    logic [RF_W-1:0]         v;

    // Keep only the contiguous prefix of valid lanes.
    always_comb begin
        enq_mask = '0;
        run      = 1'b1;
        for (int j = 0; j < LANES; j++) begin
            run         = run & ms_to_ws_valid[j];
            enq_mask[j] = run;
        end
    end

    assign ws_allowin = count <= CNT_W'(DEPTH - LANES);
    assign enq        = ws_allowin & ms_to_ws_valid[0];

    wb_commit_buf #(
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .ENT_W  (LANE_W),
        .VIEW_W (RF_W)
    ) u_buf (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (enq),
        .wr_mask   (enq_mask),
        .wr_data   (ms_to_ws_bus),
        .count     (count),
        .head_ent  (head_ent),
        .ent_valid (ent_valid),
        .ent_view  (ent_view)
    );

    assign head_vld = ent_valid[0];
    assign head_we  = head_vld & head_ent[LANE_W-1];

    assign ws_to_ds_valid = head_vld;
    assign ws_to_rf_bus   = head_vld ?
        {head_we, head_ent[LANE_W-2:PC_W]} : '0;

    assign debug_wb_pc       = head_vld ? head_ent[PC_W-1:0] : '0;
    assign debug_wb_rf_we    = {4{head_we}};
    assign debug_wb_rf_wnum  = head_vld ?
        head_ent[PC_W+DATA_W +: REG_AW] : '0;
    assign debug_wb_rf_wdata = head_vld ?
        head_ent[PC_W +: DATA_W] : '0;

    always_comb begin
        ws_fwd_valid = '0;
        ws_fwd_dest  = '0;
        ws_fwd_data  = '0;
        v            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = ent_view[i*RF_W +: RF_W];
            if (ent_valid[i]) begin
                ws_fwd_valid[i] = v[RF_W-1] &
                                  (v[DATA_W +: REG_AW] != '0);
                ws_fwd_dest[i*REG_AW +: REG_AW] = v[DATA_W +: REG_AW];
                ws_fwd_data[i*DATA_W +: DATA_W] = v[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage with a queue-based model.
module tb_wb_commit_stage;

    localparam int LANES  = 2;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int REG_AW = 5;
    localparam int LANE_W = 1 + REG_AW + DATA_W + PC_W;
    localparam int RF_W   = 1 + REG_AW + DATA_W;

    typedef logic [LANE_W-1:0] lane_t;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    ws_allowin;
    logic [LANES-1:0]        ms_to_ws_valid = '0;
    logic [LANES*LANE_W-1:0] ms_to_ws_bus;
    logic [RF_W-1:0]         ws_to_rf_bus;
    logic                    ws_to_ds_valid;
    logic [DEPTH-1:0]        ws_fwd_valid;
    logic [DEPTH*REG_AW-1:0] ws_fwd_dest;
    logic [DEPTH*DATA_W-1:0] ws_fwd_data;
    logic [PC_W-1:0]         debug_wb_pc;
    logic [3:0]              debug_wb_rf_we;
    logic [REG_AW-1:0]       debug_wb_rf_wnum;
    logic [DATA_W-1:0]       debug_wb_rf_wdata;

    lane_t lane_in [LANES];
    lane_t mq [$];
    int n_checks = 0;
    int n_pass   = 0;

    assign ms_to_ws_bus = {lane_in[1], lane_in[0]};

    always #5 clk = ~clk;

    wb_commit_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_to_rf_bus      (ws_to_rf_bus),
        .ws_to_ds_valid    (ws_to_ds_valid),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    always @(posedge clk) begin
        if (resetn) begin
            assert (ms_to_ws_valid != 2'b10)
            else $error("non-contiguous valid mask driven");
        end
    end

    function automatic lane_t mk(input logic we, input logic [4:0] d,
                                 input logic [31:0] r, input logic [31:0] p);
        return {we, d, r, p};
    endfunction

    function automatic logic [RF_W-1:0] exp_rf();
        if (mq.size() == 0) return '0;
        return mq[0][LANE_W-1:PC_W];
    endfunction

    function automatic logic [DEPTH-1:0] exp_fwd_valid();
        logic [DEPTH-1:0] m;
        m = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < mq.size())
                m[i] = mq[i][LANE_W-1] && (mq[i][PC_W+DATA_W +: REG_AW] != 0);
        end
        return m;
    endfunction

    // One clock: model pops the oldest result and appends accepted lanes.
    task automatic tick();
        bit acc;
        acc = (DEPTH - mq.size() >= LANES) && ms_to_ws_valid[0];
        @(posedge clk);
        if (!resetn) begin
            mq.delete();
        end else begin
            if (mq.size() != 0) void'(mq.pop_front());
            if (acc) begin
                for (int j = 0; j < LANES; j++)
                    if (ms_to_ws_valid[j]) mq.push_back(lane_in[j]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        ms_to_ws_valid = 2'b11;
        lane_in[0] = mk(1'b1, 5'd7, $urandom, $urandom);
        lane_in[1] = mk(1'b1, 5'd8, $urandom, $urandom);
        tick();
        tick();
        n_checks++;
        if (ws_allowin !== 1'b1) $display("FAIL reset_allowin got=%b exp=1", ws_allowin);
        else n_pass++;
        n_checks++;
        if (ws_to_rf_bus[RF_W-1] !== 1'b0) $display("FAIL reset_rf_we got=%b exp=0", ws_to_rf_bus[RF_W-1]);
        else n_pass++;
        n_checks++;
        if (ws_to_ds_valid !== 1'b0) $display("FAIL reset_ds_valid got=%b exp=0", ws_to_ds_valid);
        else n_pass++;
        n_checks++;
        if ({debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata} !== '0)
            $display("FAIL reset_debug got pc=%h we=%h n=%0d d=%h exp all 0",
                     debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
        else n_pass++;
        n_checks++;
        if (ws_fwd_valid !== '0) $display("FAIL reset_fwd_valid got=%b exp=0", ws_fwd_valid);
        else n_pass++;
        ms_to_ws_valid = '0;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        ms_to_ws_valid = 2'b01;
        lane_in[0] = mk(1'b1, 5'd3, 32'h11, 32'h1c000000);
        tick();
        ms_to_ws_valid = '0;
        n_checks++;
        if (ws_to_rf_bus !== {1'b1, 5'd3, 32'h11})
            $display("FAIL single_rf got=%h exp=%h", ws_to_rf_bus, {1'b1, 5'd3, 32'h11});
        else n_pass++;
        n_checks++;
        if (debug_wb_pc !== 32'h1c000000) $display("FAIL single_pc got=%h exp=1c000000", debug_wb_pc);
        else n_pass++;
        n_checks++;
        if (debug_wb_rf_we !== 4'hf) $display("FAIL single_dbg_we got=%h exp=f", debug_wb_rf_we);
        else n_pass++;
        n_checks++;
        if ({debug_wb_rf_wnum, debug_wb_rf_wdata} !== {5'd3, 32'h11})
            $display("FAIL single_dbg_w got=%0d/%h exp=3/11", debug_wb_rf_wnum, debug_wb_rf_wdata);
        else n_pass++;
        tick();
        n_checks++;
        if (ws_to_ds_valid !== 1'b0 || debug_wb_pc !== '0)
            $display("FAIL single_empty got v=%b pc=%h exp 0/0", ws_to_ds_valid, debug_wb_pc);
        else n_pass++;
    endtask

    task automatic test_dual();
        ms_to_ws_valid = 2'b11;
        lane_in[0] = mk(1'b1, 5'd1, 32'haa, 32'h100);
        lane_in[1] = mk(1'b1, 5'd2, 32'hbb, 32'h104);
        tick();
        ms_to_ws_valid = '0;
        n_checks++;
        if (debug_wb_pc !== 32'h100) $display("FAIL dual_pc0 got=%h exp=100", debug_wb_pc);
        else n_pass++;
        n_checks++;
        if (ws_fwd_valid !== 4'b0011) $display("FAIL dual_fwd_valid got=%b exp=0011", ws_fwd_valid);
        else n_pass++;
        n_checks++;
        if (ws_fwd_dest[9:0] !== {5'd2, 5'd1})
            $display("FAIL dual_fwd_dest got=%h exp=%h", ws_fwd_dest[9:0], {5'd2, 5'd1});
        else n_pass++;
        tick();
        n_checks++;
        if (debug_wb_pc !== 32'h104 || ws_fwd_valid !== 4'b0001)
            $display("FAIL dual_pc1 got=%h/%b exp=104/0001", debug_wb_pc, ws_fwd_valid);
        else n_pass++;
        tick();
        n_checks++;
        if (ws_to_ds_valid !== 1'b0) $display("FAIL dual_empty got=%b exp=0", ws_to_ds_valid);
        else n_pass++;
    endtask

    task automatic test_fill();
        int g;
        bit exp_allow;
        bit saw_stall;
        logic [31:0] got [$];
        g = 0;
        saw_stall = 0;
        for (int c = 0; c < 20; c++) begin
            if (g < 3) begin
                ms_to_ws_valid = 2'b11;
                lane_in[0] = mk(1'b1, 5'(4 + 2 * g), $urandom, 32'h200 + 32'(8 * g));
                lane_in[1] = mk(1'b1, 5'(5 + 2 * g), $urandom, 32'h204 + 32'(8 * g));
            end else begin
                ms_to_ws_valid = '0;
            end
            exp_allow = (DEPTH - mq.size() >= LANES);
            n_checks++;
            if (ws_allowin !== exp_allow)
                $display("FAIL fill_allowin cyc=%0d got=%b exp=%b", c, ws_allowin, exp_allow);
            else n_pass++;
            if (!exp_allow) saw_stall = 1;
            if (ws_to_ds_valid) got.push_back(debug_wb_pc);
            if (exp_allow && g < 3) g++;
            tick();
        end
        n_checks++;
        if (!saw_stall) $display("FAIL fill_stall got=0 exp=1");
        else n_pass++;
        n_checks++;
        if (got.size() != 6) $display("FAIL fill_count got=%0d exp=6", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 6; i++) begin
            n_checks++;
            if (got[i] !== 32'h200 + 32'(4 * i))
                $display("FAIL fill_order idx=%0d got=%h exp=%h", i, got[i], 32'h200 + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_hazard();
        ms_to_ws_valid = 2'b11;
        lane_in[0] = mk(1'b1, 5'd5, 32'hA, 32'h300);
        lane_in[1] = mk(1'b1, 5'd5, 32'hB, 32'h304);
        tick();
        ms_to_ws_valid = '0;
        n_checks++;
        if (ws_fwd_data[63:0] !== {32'hB, 32'hA} || ws_fwd_valid !== 4'b0011)
            $display("FAIL hazard_fwd got=%h/%b exp=0000000b0000000a/0011",
                     ws_fwd_data[63:0], ws_fwd_valid);
        else n_pass++;
        tick();
        tick();
        ms_to_ws_valid = 2'b01;
        lane_in[0] = mk(1'b1, 5'd0, 32'h77, 32'h308);
        tick();
        ms_to_ws_valid = '0;
        n_checks++;
        if (ws_fwd_valid[0] !== 1'b0 || ws_to_rf_bus[RF_W-1] !== 1'b1)
            $display("FAIL hazard_dest0 got fwd=%b we=%b exp 0/1",
                     ws_fwd_valid[0], ws_to_rf_bus[RF_W-1]);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int g = 0; g < 2; g++) begin
            ms_to_ws_valid = 2'b11;
            lane_in[0] = mk(1'b1, 5'(10 + g), $urandom, 32'h400 + 32'(8 * g));
            lane_in[1] = mk(1'b1, 5'(20 + g), $urandom, 32'h404 + 32'(8 * g));
            tick();
        end
        ms_to_ws_valid = '0;
        n_checks++;
        if (ws_fwd_valid !== 4'b0111) $display("FAIL mid_count got=%b exp=0111", ws_fwd_valid);
        else n_pass++;
        #2;
        resetn = 1'b0;
        mq.delete();
        #1;
        n_checks++;
        if (ws_to_ds_valid !== 1'b0 || ws_to_rf_bus !== '0 || debug_wb_pc !== '0 ||
            debug_wb_rf_we !== '0 || ws_fwd_valid !== '0)
            $display("FAIL mid_async got v=%b rf=%h pc=%h we=%h fwd=%b exp all 0",
                     ws_to_ds_valid, ws_to_rf_bus, debug_wb_pc, debug_wb_rf_we, ws_fwd_valid);
        else n_pass++;
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (ws_to_ds_valid !== 1'b0) $display("FAIL mid_stale cyc=%0d got=%b exp=0", c, ws_to_ds_valid);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [RF_W-1:0] erf;
        int r;
        for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 2);
            ms_to_ws_valid = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
            for (int j = 0; j < LANES; j++)
                lane_in[j] = mk(1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom);
            erf = exp_rf();
            n_checks++;
            if (ws_allowin !== (DEPTH - mq.size() >= LANES))
                $display("FAIL rnd_allowin cyc=%0d got=%b", c, ws_allowin);
            else n_pass++;
            n_checks++;
            if (ws_to_ds_valid !== (mq.size() != 0) || ws_to_rf_bus !== erf)
                $display("FAIL rnd_rf cyc=%0d got=%b/%h exp=%h", c, ws_to_ds_valid, ws_to_rf_bus, erf);
            else n_pass++;
            n_checks++;
            if (debug_wb_pc !== ((mq.size() != 0) ? mq[0][PC_W-1:0] : 32'h0) ||
                debug_wb_rf_we !== {4{erf[RF_W-1]}} ||
                debug_wb_rf_wnum !== erf[DATA_W +: REG_AW] ||
                debug_wb_rf_wdata !== erf[DATA_W-1:0])
                $display("FAIL rnd_debug cyc=%0d got pc=%h we=%h n=%0d d=%h",
                         c, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata);
            else n_pass++;
            n_checks++;
            if (ws_fwd_valid !== exp_fwd_valid())
                $display("FAIL rnd_fwd_valid cyc=%0d got=%b exp=%b", c, ws_fwd_valid, exp_fwd_valid());
            else n_pass++;
            for (int i = 0; i < mq.size(); i++) begin
                n_checks++;
                if (ws_fwd_dest[i*REG_AW +: REG_AW] !== mq[i][PC_W+DATA_W +: REG_AW] ||
                    ws_fwd_data[i*DATA_W +: DATA_W] !== mq[i][PC_W +: DATA_W])
                    $display("FAIL rnd_fwd_entry cyc=%0d idx=%0d got=%0d/%h exp=%0d/%h",
                             c, i, ws_fwd_dest[i*REG_AW +: REG_AW], ws_fwd_data[i*DATA_W +: DATA_W],
                             mq[i][PC_W+DATA_W +: REG_AW], mq[i][PC_W +: DATA_W]);
                else n_pass++;
            end
            tick();
        end
        ms_to_ws_valid = '0;
        for (int c = 0; c < 6; c++) tick();
    endtask

    initial begin
        lane_in[0] = '0;
        lane_in[1] = '0;
        test_reset();
        test_single();
        test_dual();
        test_fill();
        test_hazard();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
